// File: rtl/clock_gen_divider.sv
// Two registered clock dividers sharing one source clock, restart and reset state.
// Both outputs rise together on the first enabled edge, which keeps them phase-aligned.
module clock_gen_divider #(
    parameter logic [27:0] DIV_A = 28'd4,
    parameter logic [27:0] DIV_B = 28'd2
) (
    input  logic clock_in,
    input  logic rst,
    input  logic enable,
    output logic clock_out,
    output logic clock_out_b
);

    logic [1:0] out_vec;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_div
            localparam logic [27:0] RAW  = (gi == 0) ? DIV_A : DIV_B;
            // Ratios below 2 cannot produce a toggling clock, so they run as /2.
            localparam logic [27:0] DIV  = (RAW < 28'd2) ? 28'd2 : RAW;
            localparam logic [27:0] LAST = DIV - 28'd1;
            localparam logic [27:0] HALF = DIV >> 1;

            logic [27:0] cnt_q;
            logic [27:0] cnt_d;
            logic        out_q;
            logic        out_d;

            always_comb begin
                cnt_d = (cnt_q == LAST) ? 28'd0 : cnt_q + 28'd1;
                out_d = (cnt_d < HALF);
            end

            // Parking the counter at LAST makes the next enabled edge wrap to 0 and go high.
            always_ff @(posedge clock_in or negedge rst) begin
                if (!rst) begin
                    cnt_q <= LAST;
                    out_q <= 1'b0;
                end else if (!enable) begin
                    cnt_q <= LAST;
                    out_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    out_q <= out_d;
                end
            end

            assign out_vec[gi] = out_q;
        end
    endgenerate

    assign clock_out   = out_vec[0];
    assign clock_out_b = out_vec[1];

endmodule

// File: tb/tb_clock_gen_divider.sv
// Bench for clock_gen_divider: four instances with different ratios checked against
// a model based on the count of enabled edges since the last restart.
module tb_clock_gen_divider;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] oa;
    logic [3:0] ob;

    always #5 clk = ~clk;

    clock_gen_divider #(.DIV_A(28'd4), .DIV_B(28'd2)) u_def (
        .clock_in(clk), .rst(rst_n), .enable(en), .clock_out(oa[0]), .clock_out_b(ob[0]));
    clock_gen_divider #(.DIV_A(28'd5), .DIV_B(28'd3)) u_odd (
        .clock_in(clk), .rst(rst_n), .enable(en), .clock_out(oa[1]), .clock_out_b(ob[1]));
    clock_gen_divider #(.DIV_A(28'd1), .DIV_B(28'd7)) u_one (
        .clock_in(clk), .rst(rst_n), .enable(en), .clock_out(oa[2]), .clock_out_b(ob[2]));
    clock_gen_divider #(.DIV_A(28'd0), .DIV_B(28'd6)) u_zero (
        .clock_in(clk), .rst(rst_n), .enable(en), .clock_out(oa[3]), .clock_out_b(ob[3]));

    // Effective ratios after clamping to a minimum of 2.
    int na [4] = '{4, 5, 2, 2};
    int nb [4] = '{2, 3, 7, 6};

    int checks = 0;
    int errors = 0;
    int k      = 0;  // enabled edges since the last restart

    typedef struct {
        logic r;
        logic e;
        logic ea;
        logic eb;
    } vec_t;

    vec_t tbl[$];

    function automatic logic model(input int edges, input int n);
        if (edges == 0) return 1'b0;
        return ((edges - 1) % n) < (n / 2);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst_n = r;
        en    = e;
        @(posedge clk);
        if (!rst_n || !en) k = 0;
        else               k++;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_a[%0d]", i), oa[i], model(k, na[i]));
            chk($sformatf("model_b[%0d]", i), ob[i], model(k, nb[i]));
        end
    endtask

    initial begin
        logic [9:0] odd_pat;
        int rise_a;
        int rise_b;
        logic pa;
        logic pb;

        // Reset for 3 edges, default run, then a one-edge enable gap at counter 0.
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e);
            chk($sformatf("tbl%0d_a", i), oa[0], tbl[i].ea);
            chk($sformatf("tbl%0d_b", i), ob[0], tbl[i].eb);
            $display("vec %0d rst=%0b en=%0b out=%0b out_b=%0b", i, tbl[i].r, tbl[i].e, oa[0], ob[0]);
        end

        // Odd ratio /5: two high, three low, repeating.
        step(1'b1, 1'b0);
        odd_pat = 10'b1100011000;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("odd5_%0d", i), oa[1], odd_pat[9 - i]);
        end
        $display("odd ratio sequence done");

        // 400 enabled edges: count rising edges and check phase alignment.
        step(1'b1, 1'b0);
        rise_a = 0;
        rise_b = 0;
        pa = oa[0];
        pb = ob[0];
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'b1);
            if (!pa && oa[0]) begin
                rise_a++;
                chk("phase_align", !pb && ob[0], 1'b1);
            end
            if (!pb && ob[0]) rise_b++;
            pa = oa[0];
            pb = ob[0];
        end
        checks++;
        if (rise_a != 100) begin
            errors++;
            $display("FAIL rise_count_a actual=%0d required=100", rise_a);
        end
        checks++;
        if (rise_b != 200) begin
            errors++;
            $display("FAIL rise_count_b actual=%0d required=200", rise_b);
        end
        $display("run of 400 edges: rises a=%0d b=%0d", rise_a, rise_b);

        // Asynchronous reset between edges while clock_out is high.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("pre_async_a", oa[0], 1'b1);
        #2;
        rst_n = 1'b0;
        k     = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async_a[%0d]", i), oa[i], 1'b0);
            chk($sformatf("async_b[%0d]", i), ob[i], 1'b0);
        end
        step(1'b1, 1'b1);
        chk("post_async_a", oa[0], 1'b1);
        chk("post_async_b", ob[0], 1'b1);
        $display("async reset sequence done");

        // Randomised enables and resets against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 11) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
